// File: rtl/exe_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register.
//   mem_op_e        : memory op encodings carried on mem_op_i/mem_op_o
//   ZERO_REG        : architectural register 0 (never a hazard source)
//   WRITE_ENABLE/WRITE_DISABLE : write-enable levels
//   is_load()       : true for every op that returns data to a register
package exe_mem_pipe_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  localparam int unsigned ZERO_REG      = 0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  // Op is passed zero-extended to 32 bits so any OP_W can use it.
  function automatic logic is_load(input logic [31:0] op);
    case (op)
      32'(MEM_LB), 32'(MEM_LH), 32'(MEM_LW),
      32'(MEM_LBU), 32'(MEM_LHU): return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exe_mem_pipe_sat_counter.sv
// sat_counter: saturating up-counter used for pipeline performance counts.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears the count
//   inc_i   : increment request for this edge
//   count_o : current count; sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/exe_mem_pipe.sv
// exe_mem_pipe: EX/MEM pipeline register with valid bit, stall hold/bubble,
// flush and a decode-stage load-use hazard detector.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   stall_i                 : stall vector; only EX_IDX and MEM_IDX bits matter
//   flush_i                 : squash the entry being captured
//   valid_i + reg_* / mem_* : execute-stage instruction fields
//   id_rs1_i, id_rs2_i      : decode-stage source registers
//   valid_o + reg_* / mem_* : registered entry (bubble = all zero, MEM_NOP)
//   load_use_o              : combinational load-use hazard flag
//   bubble_cnt_o, hold_cnt_o: saturating perf counters, only when the macro
//                             EXE_MEM_PERF_EN is defined
module exe_mem_pipe
  import exe_mem_pipe_pkg::*;
#(
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned RDATA_W = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_IDX  = 3,
  parameter int unsigned MEM_IDX = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               reg_we_i,
  input  logic [RDATA_W-1:0] reg_wdata_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  mem_data_i,
  input  logic               mem_we_i,
  input  logic [OP_W-1:0]    mem_op_i,
  input  logic [RADDR_W-1:0] id_rs1_i,
  input  logic [RADDR_W-1:0] id_rs2_i,
  output logic               valid_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic               reg_we_o,
  output logic [RDATA_W-1:0] reg_wdata_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_data_o,
  output logic               mem_we_o,
  output logic [OP_W-1:0]    mem_op_o,
`ifdef EXE_MEM_PERF_EN
  output logic [31:0]        bubble_cnt_o,
  output logic [31:0]        hold_cnt_o,
`endif
  output logic               load_use_o
);

  logic take_hold;
  logic stall_bubble;
  logic unused_stall;

  // MEM stalled holds regardless of EX; the MEM-only case is illegal but
  // folds naturally into hold.
  assign take_hold    = stall_i[MEM_IDX];
  assign stall_bubble = stall_i[EX_IDX] & ~stall_i[MEM_IDX];
  assign unused_stall = ^stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_o     <= 1'b0;
      reg_waddr_o <= '0;
      reg_we_o    <= WRITE_DISABLE;
      reg_wdata_o <= '0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_we_o    <= WRITE_DISABLE;
      mem_op_o    <= OP_W'(MEM_NOP);
    end else if (!take_hold) begin
      // An invalid slot is captured as a bubble so no write can leak out.
      if (stall_bubble || !valid_i) begin
        valid_o     <= 1'b0;
        reg_waddr_o <= '0;
        reg_we_o    <= WRITE_DISABLE;
        reg_wdata_o <= '0;
        mem_addr_o  <= '0;
        mem_data_o  <= '0;
        mem_we_o    <= WRITE_DISABLE;
        mem_op_o    <= OP_W'(MEM_NOP);
      end else begin
        valid_o     <= 1'b1;
        reg_waddr_o <= reg_waddr_i;
        reg_we_o    <= reg_we_i;
        reg_wdata_o <= reg_wdata_i;
        mem_addr_o  <= mem_addr_i;
        mem_data_o  <= mem_data_i;
        mem_we_o    <= mem_we_i;
        mem_op_o    <= mem_op_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(stall_i[MEM_IDX] && !stall_i[EX_IDX]));
    end
  end

  assign load_use_o = valid_o
                    & (reg_we_o == WRITE_ENABLE)
                    & is_load(32'(mem_op_o))
                    & (reg_waddr_o != RADDR_W'(ZERO_REG))
                    & ((reg_waddr_o == id_rs1_i) | (reg_waddr_o == id_rs2_i));

`ifdef EXE_MEM_PERF_EN
  logic bubble_inc;
  logic hold_inc;

  // Reset is not a counted bubble; flush outranks hold.
  assign bubble_inc = ~rst_i & (flush_i | stall_bubble);
  assign hold_inc   = ~rst_i & ~flush_i & take_hold;

  sat_counter #(.WIDTH(32)) u_bubble_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (bubble_inc),
    .count_o (bubble_cnt_o)
  );

  sat_counter #(.WIDTH(32)) u_hold_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (hold_inc),
    .count_o (hold_cnt_o)
  );
`endif

endmodule

// File: tb/tb_exe_mem_pipe.sv
module tb_exe_mem_pipe;
  import exe_mem_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        valid;
  logic [4:0]  reg_waddr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [3:0]  mem_op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  logic        valid_q;
  logic [4:0]  reg_waddr_q;
  logic        reg_we_q;
  logic [31:0] reg_wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        mem_we_q;
  logic [3:0]  mem_op_q;
  logic        load_use;
`ifdef EXE_MEM_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] hold_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  exe_mem_pipe #(
    .RADDR_W (5),
    .RDATA_W (32),
    .ADDR_W  (32),
    .DATA_W  (32),
    .OP_W    (4),
    .STALL_W (6),
    .EX_IDX  (3),
    .MEM_IDX (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .valid_i     (valid),
    .reg_waddr_i (reg_waddr),
    .reg_we_i    (reg_we),
    .reg_wdata_i (reg_wdata),
    .mem_addr_i  (mem_addr),
    .mem_data_i  (mem_data),
    .mem_we_i    (mem_we),
    .mem_op_i    (mem_op),
    .id_rs1_i    (rs1),
    .id_rs2_i    (rs2),
    .valid_o     (valid_q),
    .reg_waddr_o (reg_waddr_q),
    .reg_we_o    (reg_we_q),
    .reg_wdata_o (reg_wdata_q),
    .mem_addr_o  (mem_addr_q),
    .mem_data_o  (mem_data_q),
    .mem_we_o    (mem_we_q),
    .mem_op_o    (mem_op_q),
`ifdef EXE_MEM_PERF_EN
    .bubble_cnt_o(bubble_cnt),
    .hold_cnt_o  (hold_cnt),
`endif
    .load_use_o  (load_use)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output kind for a row: captured inputs, bubble, or previous value.
  typedef enum logic [1:0] {E_CAP, E_BUB, E_HOLD} exp_e;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic        valid;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wd;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mwe;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    exp_e        kind;
    logic        lu;
  } vec_t;

  localparam int unsigned NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({valid_q, reg_waddr_q, reg_we_q, reg_wdata_q, mem_addr_q,
                 mem_data_q, mem_we_q, mem_op_q});
  endfunction

  task automatic drive(input vec_t v);
    rst       = v.rst;
    flush     = v.flush;
    stall     = v.stall;
    valid     = v.valid;
    reg_waddr = v.wa;
    reg_we    = v.we;
    reg_wdata = v.wd;
    mem_addr  = v.addr;
    mem_data  = v.data;
    mem_we    = v.mwe;
    mem_op    = v.op;
    rs1       = v.rs1;
    rs2       = v.rs2;
  endtask

  logic [127:0] exp_out;

  initial begin
    drive('{1'b1, 1'b0, 6'h00, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0,
            5'd0, 5'd0, E_BUB, 1'b0});

    //           rst   flush stall       valid wa     we    wd          addr        data         mwe   op                rs1    rs2    kind    lu
    vecs[0]  = '{1'b1, 1'b0, 6'b000000, 1'b0, 5'd0,  1'b0, 32'h0,      32'h0,      32'h0,       1'b0, 4'(MEM_NOP), 5'd0,  5'd0,  E_BUB,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 6'b000000, 1'b1, 5'd5,  1'b1, 32'h9,      32'h9,      32'h9,       1'b1, 4'(MEM_LW),  5'd5,  5'd5,  E_BUB,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 5'd5,  1'b1, 32'h1234,   32'h100,    32'h0,       1'b0, 4'(MEM_LW),  5'd0,  5'd5,  E_CAP,  1'b1};
    vecs[3]  = '{1'b0, 1'b0, 6'b011000, 1'b1, 5'd9,  1'b1, 32'hFFFF,   32'h400,    32'h55,      1'b1, 4'(MEM_SW),  5'd5,  5'd0,  E_HOLD, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 6'b011000, 1'b1, 5'd9,  1'b1, 32'hFFFF,   32'h400,    32'h55,      1'b1, 4'(MEM_SW),  5'd1,  5'd2,  E_HOLD, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 6'b011000, 1'b1, 5'd9,  1'b1, 32'hFFFF,   32'h400,    32'h55,      1'b1, 4'(MEM_SW),  5'd0,  5'd5,  E_HOLD, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 6'b001000, 1'b1, 5'd9,  1'b1, 32'hFFFF,   32'h400,    32'h55,      1'b1, 4'(MEM_SW),  5'd0,  5'd5,  E_BUB,  1'b0};
    vecs[7]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 5'd5,  1'b1, 32'hAA,     32'h200,    32'hDEAD,    1'b1, 4'(MEM_SW),  5'd0,  5'd5,  E_CAP,  1'b0};
    vecs[8]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 5'd0,  1'b1, 32'hBB,     32'h204,    32'h0,       1'b0, 4'(MEM_LW),  5'd0,  5'd0,  E_CAP,  1'b0};
    vecs[9]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 5'd7,  1'b1, 32'h77,     32'h300,    32'h0,       1'b0, 4'(MEM_LBU), 5'd7,  5'd1,  E_CAP,  1'b1};
    vecs[10] = '{1'b0, 1'b1, 6'b011000, 1'b1, 5'd8,  1'b1, 32'h88,     32'h308,    32'h0,       1'b0, 4'(MEM_LW),  5'd7,  5'd8,  E_BUB,  1'b0};
    vecs[11] = '{1'b0, 1'b0, 6'b000000, 1'b0, 5'd7,  1'b1, 32'h99,     32'h30C,    32'h1,       1'b1, 4'(MEM_LW),  5'd7,  5'd7,  E_BUB,  1'b0};
    vecs[12] = '{1'b0, 1'b0, 6'b000000, 1'b1, 5'd3,  1'b0, 32'h33,     32'h310,    32'h0,       1'b0, 4'(MEM_LH),  5'd3,  5'd3,  E_CAP,  1'b0};
    vecs[13] = '{1'b0, 1'b0, 6'b100111, 1'b1, 5'd4,  1'b1, 32'h5555,   32'h314,    32'h0,       1'b0, 4'(MEM_LHU), 5'd1,  5'd4,  E_CAP,  1'b1};
    vecs[14] = '{1'b1, 1'b0, 6'b011000, 1'b1, 5'd4,  1'b1, 32'h5555,   32'h314,    32'h0,       1'b0, 4'(MEM_LHU), 5'd1,  5'd4,  E_BUB,  1'b0};
    vecs[15] = '{1'b0, 1'b0, 6'b000000, 1'b1, 5'd6,  1'b1, 32'h66,     32'h318,    32'h0,       1'b0, 4'(MEM_LB),  5'd6,  5'd2,  E_CAP,  1'b1};
    vecs[16] = '{1'b0, 1'b1, 6'b000000, 1'b1, 5'd6,  1'b1, 32'h66,     32'h318,    32'h0,       1'b0, 4'(MEM_LB),  5'd6,  5'd2,  E_BUB,  1'b0};

    exp_out = '0;
    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      case (vecs[i].kind)
        E_CAP:   exp_out = 128'({1'b1, vecs[i].wa, vecs[i].we, vecs[i].wd, vecs[i].addr,
                                 vecs[i].data, vecs[i].mwe, vecs[i].op});
        E_BUB:   exp_out = '0;
        default: exp_out = exp_out;
      endcase
      check($sformatf("vec%0d outputs", i), outs(), exp_out);
      check($sformatf("vec%0d load_use", i), 128'(load_use), 128'(vecs[i].lu));
    end

    // Load-use follows decode sources with no clock edge in between.
    @(negedge clk);
    drive('{1'b0, 1'b0, 6'h00, 1'b1, 5'd10, 1'b1, 32'h10, 32'h500, 32'h0, 1'b0, 4'(MEM_LW),
            5'd0, 5'd0, E_CAP, 1'b0});
    @(posedge clk);
    #1;
    check("lu rs none", 128'(load_use), 128'(1'b0));
    rs1 = 5'd10;
    #1;
    check("lu rs1 match", 128'(load_use), 128'(1'b1));
    rs1 = 5'd11;
    rs2 = 5'd12;
    #1;
    check("lu rs mismatch", 128'(load_use), 128'(1'b0));
    rs2 = 5'd10;
    #1;
    check("lu rs2 match", 128'(load_use), 128'(1'b1));

    // Long hold: every cycle must show the same entry.
    @(negedge clk);
    stall = 6'b011000;
    valid = 1'b1;
    reg_waddr = 5'd20;
    reg_wdata = 32'hCAFE;
    mem_op = 4'(MEM_SB);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("long hold c%0d", c), outs(),
            128'({1'b1, 5'd10, 1'b1, 32'h10, 32'h500, 32'h0, 1'b0, 4'(MEM_LW)}));
    end

`ifdef EXE_MEM_PERF_EN
    @(negedge clk);
    drive('{1'b1, 1'b0, 6'b011000, 1'b1, 5'd5, 1'b1, 32'h1, 32'h1, 32'h1, 1'b0, 4'(MEM_LW),
            5'd0, 5'd0, E_BUB, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    check("perf reset bubble", 128'(bubble_cnt), 128'(0));
    check("perf reset hold", 128'(hold_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    stall = 6'b000000;
    @(negedge clk);
    stall = 6'b011000;
    repeat (3) @(negedge clk);
    check("perf hold 3", 128'(hold_cnt), 128'(3));
    check("perf bubble 0", 128'(bubble_cnt), 128'(0));
    stall = 6'b001000;
    @(negedge clk);
    check("perf bubble 1", 128'(bubble_cnt), 128'(1));
    stall = 6'b011000;
    flush = 1'b1;
    @(negedge clk);
    check("perf flush bubble", 128'(bubble_cnt), 128'(2));
    check("perf flush no hold", 128'(hold_cnt), 128'(3));
    flush = 1'b0;
    force dut.u_hold_cnt.count_o = 32'hFFFF_FFFF;
    #1;
    release dut.u_hold_cnt.count_o;
    repeat (2) @(negedge clk);
    check("perf hold saturate", 128'(hold_cnt), 128'(32'hFFFF_FFFF));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
